// File: rtl/ram_program_loader.sv
// ram_program_loader: streams bytes from a valid/ready source into the RAM
// manual-programming port, one word per 3-cycle WAIT_BYTE/WRITE/ADVANCE pass.
// Optional build macro LOADER_VERIFY_EN adds a read-back pass (VERIFY/CHECK)
// that sums the RAM contents over the bus and flags a checksum mismatch.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start; manual port released
// WAIT_BYTE | in_ready high, waiting for a source byte
// WRITE     | manual_read strobe; RAM captures switches at closing edge
// ADVANCE   | step address, or finish after the last word
// VERIFY    | (macro) RAM drives bus, accumulate read-back sum
// CHECK     | (macro) compare read-back sum with load checksum
// DONE      | one-cycle done pulse, manual_mode released
module ram_program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int WORDS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              manual_mode,
  output logic              manual_read,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] program_switches,
  output logic              ram_write_to_bus,
  input  logic [DATA_W-1:0] bus_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BYTE, S_WRITE, S_ADVANCE, S_DONE, S_VERIFY, S_CHECK
  } state_t;
  logic [DATA_W-1:0] vsum;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BYTE, S_WRITE, S_ADVANCE, S_DONE
  } state_t;
  // Without read-back the bus is never observed.
  logic unused_bus;
  assign unused_bus = ^bus_in;
  assign error      = 1'b0;
`endif

  state_t state, state_nx;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    state_nx         = state;
    in_ready         = 1'b0;
    manual_read      = 1'b0;
    done             = 1'b0;
    ram_write_to_bus = 1'b0;
    busy             = (state != S_IDLE);
    case (state)
      S_IDLE:      if (start) state_nx = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_WRITE;
      end
      S_WRITE: begin
        manual_read = 1'b1;
        state_nx    = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (address == LAST_ADDR) begin
`ifdef LOADER_VERIFY_EN
          state_nx = S_VERIFY;
`else
          state_nx = S_DONE;
`endif
        end else begin
          state_nx = S_WAIT_BYTE;
        end
      end
`ifdef LOADER_VERIFY_EN
      S_VERIFY: begin
        ram_write_to_bus = 1'b1;
        if (address == LAST_ADDR) state_nx = S_CHECK;
      end
      S_CHECK:     state_nx = S_DONE;
`endif
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default:     state_nx = S_IDLE;
    endcase
  end

  // Address, data latch, checksum and manual_mode datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      manual_mode      <= 1'b0;
      address          <= '0;
      program_switches <= '0;
      checksum         <= '0;
`ifdef LOADER_VERIFY_EN
      vsum             <= '0;
      error            <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            address     <= '0;
            checksum    <= '0;
            manual_mode <= 1'b1;
`ifdef LOADER_VERIFY_EN
            error       <= 1'b0;
`endif
          end
        end
        S_WAIT_BYTE: begin
          if (in_valid) begin
            program_switches <= in_data;
            checksum         <= checksum + in_data;
          end
        end
        S_ADVANCE: begin
          if (address != LAST_ADDR) begin
            address <= address + 1'b1;
          end else begin
`ifdef LOADER_VERIFY_EN
            manual_mode <= 1'b0;
            address     <= '0;
            vsum        <= '0;
`endif
          end
        end
`ifdef LOADER_VERIFY_EN
        S_VERIFY: begin
          vsum <= vsum + bus_in;
          if (address != LAST_ADDR) address <= address + 1'b1;
        end
        S_CHECK:  error <= (vsum != checksum);
`endif
        S_DONE:   manual_mode <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_program_loader.sv
// Bench for ram_program_loader: random byte streams against a RAM model and
// an arithmetic checksum reference. Honors LOADER_VERIFY_EN when defined.
module tb_ram_program_loader;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, manual_mode, manual_read, ram_write_to_bus;
  logic [3:0] address;
  logic [7:0] program_switches, bus_in, checksum;
  logic       busy, done, error;

  ram_program_loader #(.ADDR_W(4), .DATA_W(8), .WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .manual_mode(manual_mode), .manual_read(manual_read),
    .address(address), .program_switches(program_switches),
    .ram_write_to_bus(ram_write_to_bus), .bus_in(bus_in), .busy(busy), .done(done),
    .checksum(checksum), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ram [16];
  logic [7:0] stim [16];
  logic [3:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         rdy_viol;
  int         rwb_cnt;
  bit         corrupt;
  logic [7:0] cs_done;
  logic       err_done, post_mm, post_busy, post_err;

  // RAM model: reads drive the bus; verify-mode corruption flips one word.
  assign bus_in = ram[address] ^ ((corrupt && address == 4'd7) ? 8'h5A : 8'h00);

  always @(posedge clk) begin
    if (manual_mode && manual_read) begin
      ram[address] <= program_switches;
      wr_addr.push_back(address);
      wr_data.push_back(program_switches);
    end
    if (in_ready && (manual_read || !busy || !manual_mode)) rdy_viol++;
    if (ram_write_to_bus) rwb_cnt++;
  end

  function automatic logic [7:0] model_sum();
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(stim[i]);
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_load(input int max_gap, input bit mid_start, output bit ok);
    bit b_ok;
    wr_addr.delete();
    wr_data.delete();
    rwb_cnt = 0;
    ok = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mid_start && i == 6) start = 1'b1;
      send_byte(stim[i], $urandom_range(max_gap, 0), b_ok);
      start = 1'b0;
      if (!b_ok) ok = 1'b0;
    end
    wait_done(b_ok);
    if (!b_ok) ok = 1'b0;
    cs_done  = checksum;
    err_done = error;
    @(negedge clk);
    post_mm   = manual_mode;
    post_busy = busy;
    post_err  = error;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, manual_mode, manual_read, address, program_switches, ram_write_to_bus,
         busy, done, checksum, error} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b mm=%b addr=%h sw=%h cs=%h", busy, manual_mode,
               address, program_switches, checksum);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    bit ok;
    for (int i = 0; i < 16; i++) stim[i] = 8'(i + 1);
    rdy_viol = 0;
    run_load(0, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL full_timeout: load did not complete"); end
    n_cmp++;
    if (wr_addr.size() != 16) begin
      n_err++; $display("FAIL full_count: got %0d writes, want 16", wr_addr.size());
    end
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      n_cmp++;
      if (wr_addr[i] !== 4'(i) || wr_data[i] !== stim[i]) begin
        n_err++;
        $display("FAIL full_write%0d: got a=%h d=%h want a=%h d=%h", i, wr_addr[i], wr_data[i],
                 4'(i), stim[i]);
      end
    end
    n_cmp++;
    if (cs_done !== model_sum() || cs_done !== 8'h88) begin
      n_err++; $display("FAIL full_checksum: got %h want %h", cs_done, model_sum());
    end
    n_cmp++;
    if (post_mm !== 1'b0 || post_busy !== 1'b0) begin
      n_err++; $display("FAIL full_after: got mm=%b busy=%b want 0 0", post_mm, post_busy);
    end
    n_cmp++;
    if (rdy_viol != 0) begin
      n_err++; $display("FAIL full_ready: %0d bad in_ready cycles, want 0", rdy_viol);
    end
  endtask

  task automatic test_stalled();
    bit ok;
    for (int i = 0; i < 16; i++) begin
      stim[i] = 8'(i + 1);
      ram[i]  = 8'h00;
    end
    rdy_viol = 0;
    run_load(5, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL stall_timeout: load did not complete"); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (ram[i] !== stim[i]) begin
        n_err++; $display("FAIL stall_ram%0d: got %h want %h", i, ram[i], stim[i]);
      end
    end
    n_cmp++;
    if (cs_done !== model_sum()) begin
      n_err++; $display("FAIL stall_checksum: got %h want %h", cs_done, model_sum());
    end
    n_cmp++;
    if (rdy_viol != 0) begin
      n_err++; $display("FAIL stall_ready: %0d bad in_ready cycles, want 0", rdy_viol);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int i = 0; i < 16; i++) stim[i] = 8'hFF;
    run_load(2, 1'b1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wrap_timeout: load did not complete"); end
    n_cmp++;
    if (cs_done !== model_sum() || cs_done !== 8'hF0) begin
      n_err++; $display("FAIL wrap_checksum: got %h want %h", cs_done, model_sum());
    end
    n_cmp++;
    if (wr_addr.size() != 16 || wr_addr[0] !== 4'd0 || wr_addr[15] !== 4'd15) begin
      n_err++; $display("FAIL wrap_midstart: got %0d writes, first=%h", wr_addr.size(),
                        wr_addr.size() > 0 ? wr_addr[0] : 4'hx);
    end
  endtask

  task automatic test_abort();
    bit ok;
    for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(stim[i], $urandom_range(3, 0), ok);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, manual_mode, manual_read, address, program_switches, ram_write_to_bus,
         busy, done, checksum, error} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: got busy=%b mm=%b addr=%h sw=%h cs=%h", busy, manual_mode,
               address, program_switches, checksum);
    end
    n_cmp++;
    if (wr_addr.size() != 5) begin
      n_err++; $display("FAIL abort_count: got %0d writes, want 5", wr_addr.size());
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
    run_load(2, 1'b0, ok);
    n_cmp++;
    if (!ok || wr_addr.size() != 16 || wr_addr[0] !== 4'd0) begin
      n_err++; $display("FAIL abort_reload: ok=%b got %0d writes, want 16 from 0", ok,
                        wr_addr.size());
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (ram[i] !== stim[i]) begin
        n_err++; $display("FAIL abort_ram%0d: got %h want %h", i, ram[i], stim[i]);
      end
    end
    n_cmp++;
    if (cs_done !== model_sum()) begin
      n_err++; $display("FAIL abort_checksum: got %h want %h", cs_done, model_sum());
    end
  endtask

  task automatic test_verify();
    bit ok;
    for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
`ifdef LOADER_VERIFY_EN
    corrupt = 1'b1;
    run_load(1, 1'b0, ok);
    n_cmp++;
    if (!ok || err_done !== 1'b1 || post_err !== 1'b1) begin
      n_err++; $display("FAIL verify_corrupt: ok=%b got error=%b/%b want 1/1", ok, err_done,
                        post_err);
    end
    n_cmp++;
    if (rwb_cnt != 16) begin
      n_err++; $display("FAIL verify_bus_cycles: got %0d want 16", rwb_cnt);
    end
    corrupt = 1'b0;
    run_load(1, 1'b0, ok);
    n_cmp++;
    if (!ok || err_done !== 1'b0) begin
      n_err++; $display("FAIL verify_clean: ok=%b got error=%b want 0", ok, err_done);
    end
`else
    run_load(1, 1'b0, ok);
    n_cmp++;
    if (!ok || err_done !== 1'b0 || rwb_cnt != 0) begin
      n_err++; $display("FAIL noverify: ok=%b got error=%b bus_cycles=%0d want 0 0", ok,
                        err_done, rwb_cnt);
    end
`endif
    n_cmp++;
    if (cs_done !== model_sum()) begin
      n_err++; $display("FAIL verify_checksum: got %h want %h", cs_done, model_sum());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    corrupt  = 1'b0;
    rdy_viol = 0;
    rwb_cnt  = 0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_full_load();
    test_stalled();
    test_wrap();
    test_abort();
    test_verify();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
